// File: rtl/mips_controller_pkg.sv
// Shared encodings for the multicycle MIPS controller and its datapath:
// state codes, opcode/funct constants, ALU control codes and the control word.
package mips_controller_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned ALUC_W  = 3;
    localparam int unsigned IRW_W   = 4;

    typedef enum logic [STATE_W-1:0] {
        st_fetch1  = 4'd0,
        st_fetch2  = 4'd1,
        st_fetch3  = 4'd2,
        st_fetch4  = 4'd3,
        st_decode  = 4'd4,
        st_memadr  = 4'd5,
        st_lbrd    = 4'd6,
        st_lbwr    = 4'd7,
        st_sbwr    = 4'd8,
        st_rtypeex = 4'd9,
        st_rtypewr = 4'd10,
        st_beqex   = 4'd11,
        st_jex     = 4'd12,
        st_addiex  = 4'd13,
        st_addiwr  = 4'd14
    } state_t;

    typedef enum logic [1:0] {
        aluop_add   = 2'b00,
        aluop_sub   = 2'b01,
        aluop_funct = 2'b10
    } aluop_t;

    localparam logic [OP_W-1:0] op_rtype = 6'b000000;
    localparam logic [OP_W-1:0] op_j     = 6'b000010;
    localparam logic [OP_W-1:0] op_beq   = 6'b000100;
    localparam logic [OP_W-1:0] op_addi  = 6'b001000;
    localparam logic [OP_W-1:0] op_lb    = 6'b100000;
    localparam logic [OP_W-1:0] op_sb    = 6'b101000;

    localparam logic [FUNCT_W-1:0] funct_add = 6'b100000;
    localparam logic [FUNCT_W-1:0] funct_sub = 6'b100010;
    localparam logic [FUNCT_W-1:0] funct_and = 6'b100100;
    localparam logic [FUNCT_W-1:0] funct_or  = 6'b100101;
    localparam logic [FUNCT_W-1:0] funct_slt = 6'b101010;

    localparam logic [ALUC_W-1:0] aluc_and = 3'b000;
    localparam logic [ALUC_W-1:0] aluc_or  = 3'b001;
    localparam logic [ALUC_W-1:0] aluc_add = 3'b010;
    localparam logic [ALUC_W-1:0] aluc_sub = 3'b110;
    localparam logic [ALUC_W-1:0] aluc_slt = 3'b111;

    typedef struct packed {
        logic             memread;
        logic             memwrite;
        logic             alusrca;
        logic             memtoreg;
        logic             iord;
        logic             regdst;
        logic             regwrite;
        logic             pcwrite;
        logic             pcwritecond;
        logic [1:0]       pcsrc;
        logic [1:0]       alusrcb;
        logic [IRW_W-1:0] irwrite;
        aluop_t           aluop;
    } ctrl_t;

endpackage

// File: rtl/mips_controller_if.sv
// Controller <-> datapath bundle: instruction fields and flags in, control strobes out.
interface mips_controller_if;
    import mips_controller_pkg::*;

    logic [OP_W-1:0]    op;
    logic [FUNCT_W-1:0] funct;
    logic               zero;
    logic               memread;
    logic               memwrite;
    logic               alusrca;
    logic               memtoreg;
    logic               iord;
    logic               regdst;
    logic               regwrite;
    logic               pcen;
    logic [1:0]         pcsrc;
    logic [1:0]         alusrcb;
    logic [IRW_W-1:0]   irwrite;
    logic [ALUC_W-1:0]  alucontrol;
    logic [STATE_W-1:0] state;

    modport master (
        input  op, funct, zero,
        output memread, memwrite, alusrca, memtoreg, iord, regdst, regwrite,
               pcen, pcsrc, alusrcb, irwrite, alucontrol, state
    );

    modport slave (
        output op, funct, zero,
        input  memread, memwrite, alusrca, memtoreg, iord, regdst, regwrite,
               pcen, pcsrc, alusrcb, irwrite, alucontrol, state
    );
endinterface

// File: rtl/mips_controller_alu_decoder.sv
// ALU decoder: maps aluop and the R-type funct field to the ALU control code.
module alu_decoder
    import mips_controller_pkg::*;
(
    input  aluop_t             aluop,
    input  logic [FUNCT_W-1:0] funct,
    output logic [ALUC_W-1:0]  alucontrol
);

    always_comb begin
        alucontrol = aluc_add;
        case (aluop)
            aluop_sub: alucontrol = aluc_sub;
            aluop_funct: begin
                case (funct)
                    funct_sub: alucontrol = aluc_sub;
                    funct_and: alucontrol = aluc_and;
                    funct_or:  alucontrol = aluc_or;
                    funct_slt: alucontrol = aluc_slt;
                    default:   alucontrol = aluc_add;
                endcase
            end
            default: alucontrol = aluc_add;
        endcase
    end

endmodule

// File: rtl/mips_controller.sv
// Multicycle MIPS controller: Moore FSM over a byte-wide instruction fetch,
// outputs decoded straight from the state register so reset acts without a clock.
module mips_controller
    import mips_controller_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    mips_controller_if.master  bus
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= st_fetch1;
        else        state_q <= state_d;
    end

    // Next state and per-state control word; anything not set stays 0.
    always_comb begin
        ctrl    = '0;
        state_d = st_fetch1;
        case (state_q)
            st_fetch1, st_fetch2, st_fetch3, st_fetch4: begin
                ctrl.memread = 1'b1;
                ctrl.alusrcb = 2'b01;
                ctrl.pcwrite = 1'b1;
                case (state_q)
                    st_fetch1: begin ctrl.irwrite = 4'b0001; state_d = st_fetch2; end
                    st_fetch2: begin ctrl.irwrite = 4'b0010; state_d = st_fetch3; end
                    st_fetch3: begin ctrl.irwrite = 4'b0100; state_d = st_fetch4; end
                    default:   begin ctrl.irwrite = 4'b1000; state_d = st_decode; end
                endcase
            end
            st_decode: begin
                ctrl.alusrcb = 2'b11;
                case (bus.op)
                    op_lb, op_sb: state_d = st_memadr;
                    op_rtype:     state_d = st_rtypeex;
                    op_beq:       state_d = st_beqex;
                    op_j:         state_d = st_jex;
                    op_addi:      state_d = st_addiex;
                    default:      state_d = st_fetch1;
                endcase
            end
            st_memadr: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = 2'b10;
                state_d      = (bus.op == op_lb) ? st_lbrd : st_sbwr;
            end
            st_lbrd: begin
                ctrl.memread = 1'b1;
                ctrl.iord    = 1'b1;
                state_d      = st_lbwr;
            end
            st_lbwr: begin
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = 1'b1;
            end
            st_sbwr: begin
                ctrl.memwrite = 1'b1;
                ctrl.iord     = 1'b1;
            end
            st_rtypeex: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = aluop_funct;
                state_d      = st_rtypewr;
            end
            st_rtypewr: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = 1'b1;
            end
            st_beqex: begin
                ctrl.alusrca     = 1'b1;
                ctrl.aluop       = aluop_sub;
                ctrl.pcsrc       = 2'b01;
                ctrl.pcwritecond = 1'b1;
            end
            st_jex: begin
                ctrl.pcsrc   = 2'b10;
                ctrl.pcwrite = 1'b1;
            end
            st_addiex: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = 2'b10;
                state_d      = st_addiwr;
            end
            st_addiwr: begin
                ctrl.regwrite = 1'b1;
            end
            default: state_d = st_fetch1;
        endcase
    end

    alu_decoder u_alu_decoder (
        .aluop      (ctrl.aluop),
        .funct      (bus.funct),
        .alucontrol (bus.alucontrol)
    );

    // Write strobes are gated by reset so nothing fires while it is held.
    assign bus.memread  = ctrl.memread  & reset;
    assign bus.memwrite = ctrl.memwrite & reset;
    assign bus.regwrite = ctrl.regwrite & reset;
    assign bus.irwrite  = ctrl.irwrite  & {IRW_W{reset}};
    assign bus.pcen     = reset & (ctrl.pcwrite | (ctrl.pcwritecond & bus.zero));
    assign bus.alusrca  = ctrl.alusrca;
    assign bus.memtoreg = ctrl.memtoreg;
    assign bus.iord     = ctrl.iord;
    assign bus.regdst   = ctrl.regdst;
    assign bus.pcsrc    = ctrl.pcsrc;
    assign bus.alusrcb  = ctrl.alusrcb;
    assign bus.state    = STATE_W'(state_q);

endmodule

// File: tb/tb_mips_controller.sv
// Scoreboard bench for mips_controller: stimulus queues hand-written expected
// outputs per cycle, a monitor pops and compares them mid-cycle.
module tb_mips_controller;
    import mips_controller_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mips_controller_if bus();

    mips_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // {memread, memwrite, alusrca, memtoreg, iord, regdst, regwrite, pcsrc, alusrcb, irwrite}
    localparam logic [14:0] W_F1   = 15'b1000000_00_01_0001;
    localparam logic [14:0] W_F2   = 15'b1000000_00_01_0010;
    localparam logic [14:0] W_F3   = 15'b1000000_00_01_0100;
    localparam logic [14:0] W_F4   = 15'b1000000_00_01_1000;
    localparam logic [14:0] W_RST  = 15'b0000000_00_01_0000;
    localparam logic [14:0] W_DEC  = 15'b0000000_00_11_0000;
    localparam logic [14:0] W_MEM  = 15'b0010000_00_10_0000;
    localparam logic [14:0] W_LBRD = 15'b1000100_00_00_0000;
    localparam logic [14:0] W_LBWR = 15'b0001001_00_00_0000;
    localparam logic [14:0] W_SBWR = 15'b0100100_00_00_0000;
    localparam logic [14:0] W_RX   = 15'b0010000_00_00_0000;
    localparam logic [14:0] W_RW   = 15'b0000011_00_00_0000;
    localparam logic [14:0] W_BEQ  = 15'b0010000_01_00_0000;
    localparam logic [14:0] W_J    = 15'b0000000_10_00_0000;
    localparam logic [14:0] W_AW   = 15'b0000001_00_00_0000;

    typedef struct {
        logic [3:0]  st;
        logic [14:0] ctl;
        logic [2:0]  aluc;
        logic        pcen;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic expect_now(input logic [3:0] st, input logic [14:0] ctl,
                              input logic [2:0] aluc, input logic pcen, input string name);
        exp_t e;
        e.st = st; e.ctl = ctl; e.aluc = aluc; e.pcen = pcen; e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic [3:0] st, input logic [14:0] ctl,
                        input logic [2:0] aluc, input logic pcen, input string name);
        expect_now(st, ctl, aluc, pcen, name);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_decode();
        step(4'd0, W_F1, 3'b010, 1'b1, "fetch1");
        step(4'd1, W_F2, 3'b010, 1'b1, "fetch2");
        step(4'd2, W_F3, 3'b010, 1'b1, "fetch3");
        step(4'd3, W_F4, 3'b010, 1'b1, "fetch4");
        step(4'd4, W_DEC, 3'b010, 1'b0, "decode");
    endtask

    // Monitor: samples once per cycle mid-cycle, and right after an async reset edge.
    initial begin
        logic [14:0] act_ctl;
        exp_t e;
        forever begin
            @(negedge clk or negedge reset);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                act_ctl = {bus.memread, bus.memwrite, bus.alusrca, bus.memtoreg, bus.iord,
                           bus.regdst, bus.regwrite, bus.pcsrc, bus.alusrcb, bus.irwrite};
                n_total++;
                if (bus.state === e.st && act_ctl === e.ctl &&
                    bus.alucontrol === e.aluc && bus.pcen === e.pcen)
                    n_pass++;
                else
                    $display("FAIL %s: got state=%0d ctl=%b aluc=%b pcen=%b, expected state=%0d ctl=%b aluc=%b pcen=%b",
                             e.name, bus.state, act_ctl, bus.alucontrol, bus.pcen,
                             e.st, e.ctl, e.aluc, e.pcen);
            end
        end
    end

    logic [5:0] sweep_funct [5] = '{6'b100100, 6'b100101, 6'b101010, 6'b100010, 6'b000000};
    logic [2:0] sweep_aluc  [5] = '{3'b000, 3'b001, 3'b111, 3'b110, 3'b010};

    initial begin
        reset     = 1'b0;
        bus.op    = 6'b000000;
        bus.funct = 6'b100000;
        bus.zero  = 1'b0;
        @(posedge clk);
        #1;
        step(4'd0, W_RST, 3'b010, 1'b0, "in_reset");
        step(4'd0, W_RST, 3'b010, 1'b0, "in_reset_hold");

        // R-type add
        reset = 1'b1;
        fetch_decode();
        step(4'd9,  W_RX, 3'b010, 1'b0, "rtypeex_add");
        step(4'd10, W_RW, 3'b010, 1'b0, "rtypewr");

        // BEQ taken, then not taken
        bus.op = 6'b000100; bus.zero = 1'b1;
        fetch_decode();
        step(4'd11, W_BEQ, 3'b110, 1'b1, "beq_taken");
        bus.zero = 1'b0;
        fetch_decode();
        step(4'd11, W_BEQ, 3'b110, 1'b0, "beq_not_taken");

        // LB then SB
        bus.op = 6'b100000;
        fetch_decode();
        step(4'd5, W_MEM,  3'b010, 1'b0, "lb_memadr");
        step(4'd6, W_LBRD, 3'b010, 1'b0, "lbrd");
        step(4'd7, W_LBWR, 3'b010, 1'b0, "lbwr");
        bus.op = 6'b101000;
        fetch_decode();
        step(4'd5, W_MEM,  3'b010, 1'b0, "sb_memadr");
        step(4'd8, W_SBWR, 3'b010, 1'b0, "sbwr");

        // J and ADDI
        bus.op = 6'b000010;
        fetch_decode();
        step(4'd12, W_J, 3'b010, 1'b1, "jex");
        bus.op = 6'b001000;
        fetch_decode();
        step(4'd13, W_MEM, 3'b010, 1'b0, "addiex");
        step(4'd14, W_AW,  3'b010, 1'b0, "addiwr");

        // Illegal opcode: decode goes straight back to fetch1, zero must not leak into pcen
        bus.op = 6'b111111; bus.zero = 1'b1;
        fetch_decode();
        bus.zero = 1'b0;

        // Funct sweep in RTYPEEX
        bus.op = 6'b000000;
        for (int i = 0; i < 5; i++) begin
            bus.funct = sweep_funct[i];
            fetch_decode();
            step(4'd9,  W_RX, sweep_aluc[i], 1'b0, "funct_sweep");
            step(4'd10, W_RW, 3'b010, 1'b0, "funct_sweep_wr");
        end

        // Async reset in the middle of RTYPEWR
        bus.funct = 6'b100000;
        fetch_decode();
        step(4'd9, W_RX, 3'b010, 1'b0, "rtypeex_pre_reset");
        expect_now(4'd10, W_RW, 3'b010, 1'b0, "rtypewr_pre_reset");
        @(negedge clk);
        #2;
        expect_now(4'd0, W_RST, 3'b010, 1'b0, "async_reset");
        reset = 1'b0;
        @(posedge clk);
        #1;
        step(4'd0, W_RST, 3'b010, 1'b0, "reset_hold_after_abort");
        reset = 1'b1;
        fetch_decode();
        step(4'd9,  W_RX, 3'b010, 1'b0, "rtypeex_after_reset");
        step(4'd10, W_RW, 3'b010, 1'b0, "rtypewr_after_reset");
        step(4'd0,  W_F1, 3'b010, 1'b1, "fetch1_next");

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
